// File: rtl/tausworthe_arbiter.sv
// tausworthe_arbiter: shares one free-running 32-bit Tausworthe word stream
// among N_REQ consumers. After reset, the first WARMUP valid words are thrown
// away. After that, the freshest word sits in a holding register. Each held
// word goes to exactly one requester, picked round-robin.
// Optional feature: define TAUS_ARB_STATS_EN to add the saturating drop_cnt
// port, which counts held words overwritten before anyone took them.
module tausworthe_arbiter #(
  parameter int N_REQ  = 4,
  parameter int WARMUP = 16,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      gen_data,
  input  logic             gen_valid,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [31:0]      rnd_data,
  output logic             rnd_valid,
  output logic             ready
`ifdef TAUS_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] drop_cnt
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  // Index of the last discarded word; clamped so WARMUP==0 still elaborates.
  localparam int WARM_LAST = (WARMUP > 0) ? WARMUP - 1 : 0;

  typedef enum logic {ST_WARMUP, ST_RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   warm_cnt_q, warm_cnt_d;
  logic               hold_full_q, hold_full_d;
  logic [31:0]        hold_data_q, hold_data_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [31:0]        rnd_data_q, rnd_data_d;
  logic               rnd_valid_q, rnd_valid_d;
  logic               ready_q, ready_d;

  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic               grant;

  // Adds an offset below N_REQ to a pointer below N_REQ, modulo N_REQ.
  // A single subtract is enough because the sum stays below 2*N_REQ.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p,
                                                input int k);
    int s;
    s = int'(p) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return PTR_W'(s);
  endfunction

  // Round-robin pick: the first set req bit, searching from rr_ptr upward.
  // The loop runs from the far end downward, so the nearest hit is written last and wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[wrap_add(rr_ptr_q, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(rr_ptr_q, k);
      end
    end
  end

  // A grant consumes the word held before this edge.
  assign grant = (state_q == ST_RUN) && hold_full_q && sel_found;

  // Next-state logic: warm-up counting, the holding register and the registered grant.
  always_comb begin
    state_d     = state_q;
    warm_cnt_d  = warm_cnt_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = '0;
    rnd_data_d  = rnd_data_q;
    rnd_valid_d = 1'b0;
    ready_d     = ready_q;
    case (state_q)
      ST_WARMUP: begin
        if (WARMUP == 0) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else if (gen_valid) begin
          warm_cnt_d = warm_cnt_q + 1'b1;
          if (warm_cnt_q == CNT_W'(WARM_LAST)) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end
        end
      end
      default: begin
        if (grant) begin
          gnt_d[sel_idx] = 1'b1;
          rnd_data_d     = hold_data_q;
          rnd_valid_d    = 1'b1;
          rr_ptr_d       = wrap_add(sel_idx, 1);
        end
        // A new word always lands; it either refills behind a consume or
        // overwrites an unclaimed word, so the freshest word wins.
        if (gen_valid) begin
          hold_data_d = gen_data;
          hold_full_d = 1'b1;
        end else if (grant) begin
          hold_full_d = 1'b0;
        end
      end
    endcase
  end

  // State register; reset aborts any pending delivery and restarts warm-up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_WARMUP;
      warm_cnt_q  <= '0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      rnd_data_q  <= '0;
      rnd_valid_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      warm_cnt_q  <= warm_cnt_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      rnd_data_q  <= rnd_data_d;
      rnd_valid_q <= rnd_valid_d;
      ready_q     <= ready_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd_data  = rnd_data_q;
  assign rnd_valid = rnd_valid_q;
  assign ready     = ready_q;

`ifdef TAUS_ARB_STATS_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Drop counter: a full holding register overwritten with no consume, saturating.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if ((state_q == ST_RUN) && gen_valid && hold_full_q && !grant &&
        (drop_cnt_q != {CNT_W{1'b1}}))
      drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tausworthe_arbiter.sv
// Scoreboard bench for tausworthe_arbiter. When a word is driven, the
// expected {gnt, data} delivery is pushed to a queue. A negedge monitor pops
// and compares it whenever rnd_valid is high.
module tb_tausworthe_arbiter;
  localparam int N = 4;
  localparam int WU = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   gen_data;
  logic          gen_valid;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [31:0]   rnd_data;
  logic          rnd_valid;
  logic          ready;
`ifdef TAUS_ARB_STATS_EN
  logic [CW-1:0] drop_cnt;
`endif

  tausworthe_arbiter #(.N_REQ(N), .WARMUP(WU), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .gen_data(gen_data), .gen_valid(gen_valid),
    .req(req), .gnt(gnt), .rnd_data(rnd_data), .rnd_valid(rnd_valid),
    .ready(ready)
`ifdef TAUS_ARB_STATS_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] g;
    logic [31:0]  d;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   wn    = 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: every delivery must match the next scoreboard entry.
  always @(negedge clk) begin
    if (!rst) begin
      chk("vld_eq_or_gnt", {63'd0, rnd_valid}, {63'd0, |gnt});
      if (rnd_valid) begin
        if (sb.size() == 0) chk("spurious_gnt", {63'd0, rnd_valid}, 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("gnt", 64'(gnt), 64'(e.g));
          chk("data", 64'(rnd_data), 64'(e.d));
        end
      end
    end
  end

  // Drive one generator word for one cycle, optionally expecting its delivery.
  task automatic word(input logic [31:0] d, input bit push, input logic [N-1:0] eg);
    gen_valid = 1'b1;
    gen_data  = d;
    if (push) sb.push_back('{g: eg, d: d});
    @(posedge clk); #1;
    gen_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // Warm-up from reset: WU words are discarded, with ready checked after each one.
  task automatic warmup(input string tag);
    for (int n = 1; n <= WU; n++) begin
      word(wn, 1'b0, '0);
      wn++;
      chk(tag, {63'd0, ready}, {63'd0, n >= WU});
    end
  endtask

  initial begin
    rst = 1'b1; gen_valid = 1'b0; gen_data = '0; req = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_vld", {63'd0, rnd_valid}, 64'd0);
    chk("rst_data", 64'(rnd_data), 64'd0);
    chk("rst_ready", {63'd0, ready}, 64'd0);
`ifdef TAUS_ARB_STATS_EN
    chk("rst_drop", 64'(drop_cnt), 64'd0);
`endif
    rst = 1'b0;
    req = 4'b1111;

    // Warm-up, then full round-robin on a continuous stream (words 17..36).
    warmup("wu_ready");
    for (int k = 0; k < 20; k++) begin
      word(wn, 1'b1, 4'b0001 << (k % 4));
      wn++;
    end
    drain("rr_drain");

    // Sparse requesters: only 0 and 2, alternating.
    req = 4'b0101;
    for (int k = 0; k < 8; k++) begin
      word(wn, 1'b1, (k % 2) ? 4'b0100 : 4'b0001);
      wn++;
    end
    drain("sparse_drain");

    // Empty hold, then a single pulse that is delivered exactly two cycles later.
    req = 4'b0001;
    repeat (5) @(posedge clk);
    #1;
    word(32'hDEADBEEF, 1'b1, 4'b0001);
    @(negedge clk);
    chk("eh_t1_vld", {63'd0, rnd_valid}, 64'd0);
    @(negedge clk);
    chk("eh_t2_vld", {63'd0, rnd_valid}, 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("eh_drain", 64'(sb.size()), 64'd0);

    // Reset mid-run while gnt=0100 is being presented.
    req = 4'b0100;
    word(32'h0BAD0100, 1'b1, 4'b0100);
    for (int i = 0; i < 10 && gnt !== 4'b0100; i++) begin
      @(negedge clk); #1;
    end
    chk("rm_gnt_seen", 64'(gnt), 64'h4);
    rst = 1'b1;
    #1;
    chk("rm_gnt", 64'(gnt), 64'd0);
    chk("rm_vld", {63'd0, rnd_valid}, 64'd0);
    chk("rm_ready", {63'd0, ready}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    req = 4'b1111;
    warmup("rm_wu_ready");
    for (int k = 0; k < 4; k++) begin
      word(wn, 1'b1, 4'b0001 << k);
      wn++;
    end
    drain("rm_drain");

`ifdef TAUS_ARB_STATS_EN
    // Nobody requesting: every word after the first overwrites an unclaimed one.
    chk("drop_base", 64'(drop_cnt), 64'd0);
    req = '0;
    for (int k = 0; k < 10; k++) begin
      word(wn, 1'b0, '0);
      wn++;
    end
    chk("drop_9", 64'(drop_cnt), 64'd9);
    for (int k = 0; k < 30; k++) begin
      word(wn, 1'b0, '0);
      wn++;
    end
    chk("drop_sat", 64'(drop_cnt), 64'd15);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tausworthe_arbiter.md
Name: tausworthe_arbiter

Overview:
- Shares one free-running 32-bit Tausworthe generator stream (tausworthe output word plus its valid) among N_REQ consumers.
- After reset it discards a warm-up run of words, then holds one fresh word in a holding register.
- Each held word goes to exactly one requester, chosen by round-robin grant.
- Sits between the generator and downstream blocks that need random words (noise injectors, test-pattern sources).

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WARMUP, 16, number of generator-valid words discarded after reset (0 allowed).
- CNT_W, 16, width of the warm-up counter and of the optional drop counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- gen_data  in  32  generator output word.
- gen_valid  in  1  gen_data valid this cycle (AND of generator stage valids).
- req  in  N_REQ  level request per consumer; held high while a word is wanted.
- gnt  out  N_REQ  one-hot, one-cycle grant. Consumer i takes rnd_data when gnt[i]=1.
- rnd_data  out  32  delivered word; holds its last value when rnd_valid=0.
- rnd_valid  out  1  equals |gnt.
- ready  out  1  high once warm-up is complete.
- drop_cnt  out  CNT_W  discarded-word count (present only with the optional feature).

Behaviour:
- Reset (async, rst=1):
  - state=WARMUP, warm_cnt=0, hold_full=0, hold_data=0, rr_ptr=0.
  - gnt=0, rnd_valid=0, rnd_data=0, ready=0, drop_cnt=0.
  - Asserting reset mid-operation aborts any pending delivery. Outputs clear immediately and warm-up repeats.
- State WARMUP:
  - Each gen_valid cycle increments warm_cnt. No load, no grant.
  - The gen_valid cycle with warm_cnt==WARMUP-1 moves to RUN on the next edge, and ready=1 from that edge.
  - If WARMUP==0, go to RUN on the first clock edge after reset release.
- State RUN: stays in RUN until reset.
- Holding register (RUN only):
  - On gen_valid, hold_data<=gen_data and hold_full<=1.
  - Consume: a grant issued on edge t consumes the word that was held before t.
  - If a consume and gen_valid coincide on the same edge, the new word is loaded and hold_full stays 1. No drop.
  - If gen_valid and hold_full and no consume on that edge, the old word is overwritten (freshest word wins) and counts as one drop.
  - If a consume occurs without gen_valid, hold_full<=0.
- Grant (registered):
  - If hold_full and |req at cycle t, then at t+1: gnt = one-hot of the first set req bit searching rr_ptr, rr_ptr+1, ... mod N_REQ.
  - At the same t+1: rnd_data=hold_data and rnd_valid=1.
  - After granting index i, rr_ptr<=(i+1) mod N_REQ.
  - With no grant: gnt=0, rnd_valid=0, rr_ptr unchanged.
- Sustained throughput:
  - One word per cycle with gen_valid continuous and req non-zero.
  - Each word is delivered at most once and never to two requesters.
- Latency: gen_valid at edge t gives hold_full at t+1; with req high, gnt is at t+2.
- req dropping after grant decision time has no effect on the already-registered grant.

Optional Feature:
- Macro TAUS_ARB_STATS_EN.
  - Defined: drop_cnt port exists. It increments by 1 on each overwrite-drop in RUN and saturates at 2^CNT_W-1. Reset clears it to 0.
  - Undefined: port and counter are absent. Drop handling is otherwise identical.

Test Plan:
- Warm-up: N_REQ=4, WARMUP=16, gen_valid=1 every cycle, gen_data=1,2,3,..., req=4'b1111 from reset.
  - No gnt and ready=0 for the first 16 words.
  - ready=1 after word 16.
  - First delivered rnd_data=17.
- Full round-robin: RUN, req=4'b1111, gen_valid continuous.
  - gnt cycles 0001,0010,0100,1000,0001 on consecutive cycles.
  - rnd_data strictly increasing, no repeats.
- Sparse requesters: RUN, req=4'b0101.
  - gnt alternates 0001,0100.
  - 0010 and 1000 are never granted.
- Empty hold: RUN, hold empty, req=4'b0001, gen_valid=0; then a single gen_valid pulse with 32'hDEADBEEF at cycle t.
  - gnt=0001 and rnd_data=32'hDEADBEEF at t+2.
  - No further gnt.
- Reset mid-run: assert rst during a cycle with gnt=0100.
  - gnt, rnd_valid and ready drop to 0 without waiting for a clock edge.
  - After release, 16 more warm-up words pass before the next gnt.
- Stats (TAUS_ARB_STATS_EN): RUN, req=0, gen_valid for 10 cycles → drop_cnt=9.
  - With CNT_W=4 and 40 cycles, drop_cnt saturates at 15.
